sample_stream_fifo: RTL and testbench
=====================================

# sample_stream_fifo

Parametrised ready/valid stream buffer for the simulator-regression test designs. It generalises the fixed 8-bit stream_in/stream_out handshake into a configurable-width, configurable-depth FIFO with occupancy, almost-full and transfer-count status. The extra status exists so cocotb tests can exercise backpressure, wrap-around and flush behaviour across simulators.

## Interface
Parameters:
- DATA_WIDTH, default 8: payload width in bits, valid range 1..128.
- DEPTH, default 4: number of storage entries; must be a power of two ≥ 2. ADDR_W = $clog2(DEPTH).
- AFULL_LEVEL, default DEPTH-1: occupancy at or above which almost_full asserts; valid range 1..DEPTH.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  reset, synchronous and active-low.
- flush  input  1  synchronous clear of FIFO contents.
- stream_in_valid  input  1  producer has a word.
- stream_in_ready  output  1  FIFO can accept a word.
- stream_in_data  input  DATA_WIDTH  producer payload.
- stream_out_valid  output  1  FIFO holds a word.
- stream_out_ready  input  1  consumer accepts the word.
- stream_out_data  output  DATA_WIDTH  head-of-FIFO payload.
- level  output  ADDR_W+1  current occupancy, 0..DEPTH.
- almost_full  output  1  high when level ≥ AFULL_LEVEL.
- out_count  output  32  number of words read since reset, wrapping.

## Operation
- Storage: DEPTH×DATA_WIDTH array. The array is not reset.
- Pointers: wr_ptr and rd_ptr are ADDR_W bits wide. Each wraps naturally from DEPTH-1 to 0.
- Count register: ADDR_W+1 bits wide.
- Write fires when stream_in_valid && stream_in_ready. It stores stream_in_data at wr_ptr and increments wr_ptr.
- Read fires when stream_out_valid && stream_out_ready. It increments rd_ptr and increments out_count.
- Count update: +1 on write only, −1 on read only, unchanged when both fire.
- stream_in_ready = rst_n && (count != DEPTH).
  - It depends only on registered state, never on stream_out_ready.
  - When full, a same-cycle read does not open the input.
- stream_out_valid = (count != 0).
- stream_out_data = mem[rd_ptr] when count != 0, otherwise all zeros. This is a combinational read of the array (show-ahead).
- level = count.
- almost_full = (count ≥ AFULL_LEVEL), combinational from count.
- flush (when rst_n is high):
  - takes priority over any write or read in the same cycle;
  - wr_ptr, rd_ptr and count go to 0;
  - neither the write nor the read fires;
  - out_count is unchanged;
  - stream_in_ready and stream_out_valid still show their pre-flush values during the flush cycle.
- out_count wraps from 0xFFFF_FFFF to 0 with no sticky flag.
- A producer holding stream_in_valid while stream_in_ready is low must not lose data. The FIFO only samples data on handshake cycles.
- While stream_out_valid && !stream_out_ready, stream_out_data is held stable: rd_ptr does not move, and mem[rd_ptr] cannot be overwritten because the FIFO is not full past the head.

## Timing
- Reset (rst_n low at a rising edge): from the next cycle, count, wr_ptr, rd_ptr and out_count are 0. Resulting outputs:
  - stream_out_valid 0;
  - stream_out_data 0;
  - level 0;
  - almost_full 0, unless AFULL_LEVEL would be met at 0, which the parameter range excludes;
  - out_count 0.
- stream_in_ready is 0 whenever rst_n is low (combinational), and 1 in the first cycle after release.
- Reset mid-operation discards all contents. Handshakes in the reset cycle have no effect.
- Latency: a word written at edge N appears on stream_out_* in the cycle after edge N, i.e. 1 cycle. There is no combinational in→out path.
- Throughput: one word per cycle in each direction at steady state when 0 < level < DEPTH.
- Full boundary: at count == DEPTH, stream_in_ready is low. A read at edge N raises stream_in_ready in the cycle after N.
- Empty boundary: at count == 0, stream_out_valid is low. stream_out_ready is ignored.
- A write into an empty FIFO at edge N gives stream_out_valid high after N.

## Test plan
- Reset/idle: hold rst_n low for 3 cycles with stream_in_valid=1 → stream_in_ready=0, stream_out_valid=0, level=0, out_count=0; after release, stream_in_ready=1 within 1 cycle.
- Fill to full (DATA_WIDTH=8, DEPTH=4, AFULL_LEVEL=3), stream_out_ready=0, write 0x11,0x22,0x33,0x44,0x55 → first four accepted; 0x55 held off (stream_in_ready=0); level=4; almost_full rises after the third write; stream_out_data=0x11 stable throughout.
- Drain with wrap: continue from full; read 2 words, write 0x55,0x66, read all → output order 0x11,0x22,0x33,0x44,0x55,0x66; out_count=6; level=0; pointers wrapped with no corruption.
- Simultaneous read+write at level 2 for 10 cycles with an incrementing pattern → level stays 2; data in order; 1-cycle latency through an empty FIFO verified separately.
- Flush during a write+read cycle at level 3 → next cycle level=0, stream_out_valid=0, stream_out_data=0; the flushed-cycle write is not stored; out_count unchanged.
- Wide config (DATA_WIDTH=128, DEPTH=16): random valid/ready throttling over 1000 words against a scoreboard → no loss, duplication or reorder; out_count=1000.

Source files
------------

// File: rtl/sample_stream_fifo.sv
// Parametrised ready/valid stream FIFO with show-ahead output, occupancy,
// almost-full and a wrapping count of words read since reset.
module sample_stream_fifo #(
   parameter  int unsigned DATA_WIDTH  = 8,
   parameter  int unsigned DEPTH       = 4,
   parameter  int unsigned AFULL_LEVEL = DEPTH - 1,
   localparam int unsigned ADDR_W      = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic                  stream_in_valid,
   output logic                  stream_in_ready,
   input  logic [DATA_WIDTH-1:0] stream_in_data,
   output logic                  stream_out_valid,
   input  logic                  stream_out_ready,
   output logic [DATA_WIDTH-1:0] stream_out_data,
   output logic [ADDR_W:0]       level,
   output logic                  almost_full,
   output logic [31:0]           out_count
);

   localparam logic [ADDR_W:0] L_FULL  = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W:0] L_AFULL = (ADDR_W + 1)'(AFULL_LEVEL);
   localparam logic [ADDR_W:0] L_ONE   = (ADDR_W + 1)'(1);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [ADDR_W-1:0]     r_wr_ptr;
   logic [ADDR_W-1:0]     r_rd_ptr;
   logic [ADDR_W:0]       r_count;
   logic [31:0]           r_out_count;

   logic w_wr;
   logic w_rd;

   // Ready is derived from registered occupancy only, so a read while full
   // never opens the input in the same cycle.
   assign stream_in_ready  = rst_n && (r_count != L_FULL);
   assign stream_out_valid = (r_count != '0);
   assign stream_out_data  = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
   assign level            = r_count;
   assign almost_full      = (r_count >= L_AFULL);
   assign out_count        = r_out_count;

   assign w_wr = stream_in_valid && stream_in_ready && !flush;
   assign w_rd = stream_out_valid && stream_out_ready && !flush;

   always_ff @(posedge clk) begin
      if (rst_n && w_wr) begin
         r_mem[r_wr_ptr] <= stream_in_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_out_count <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr) begin
            r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
         end
         if (w_rd) begin
            r_rd_ptr    <= r_rd_ptr + ADDR_W'(1);
            r_out_count <= r_out_count + 32'd1;
         end
         case ({w_wr, w_rd})
            2'b10:   r_count <= r_count + L_ONE;
            2'b01:   r_count <= r_count - L_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: tb/tb_sample_stream_fifo.sv
// Self-checking bench: queue-based reference models for a small (8x4) and a
// wide (128x16) instance, per-cycle output compare plus directed literal checks.
module tb_sample_stream_fifo;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ---------------- small instance: 8 bits, 4 deep, almost-full at 3
   logic        s_rst_n = 1'b0, s_flush = 1'b0, s_iv = 1'b0, s_ordy = 1'b0;
   logic [7:0]  s_id = '0;
   logic        s_irdy, s_ovalid, s_afull;
   logic [7:0]  s_odata;
   logic [2:0]  s_level;
   logic [31:0] s_oc;

   sample_stream_fifo #(.DATA_WIDTH(8), .DEPTH(4), .AFULL_LEVEL(3)) u_small (
      .clk(clk), .rst_n(s_rst_n), .flush(s_flush),
      .stream_in_valid(s_iv), .stream_in_ready(s_irdy), .stream_in_data(s_id),
      .stream_out_valid(s_ovalid), .stream_out_ready(s_ordy), .stream_out_data(s_odata),
      .level(s_level), .almost_full(s_afull), .out_count(s_oc)
   );

   // ---------------- wide instance: 128 bits, 16 deep, default almost-full (15)
   logic         w_rst_n = 1'b0, w_flush = 1'b0, w_iv = 1'b0, w_ordy = 1'b0;
   logic [127:0] w_id = '0;
   logic         w_irdy, w_ovalid, w_afull;
   logic [127:0] w_odata;
   logic [4:0]   w_level;
   logic [31:0]  w_oc;

   sample_stream_fifo #(.DATA_WIDTH(128), .DEPTH(16)) u_wide (
      .clk(clk), .rst_n(w_rst_n), .flush(w_flush),
      .stream_in_valid(w_iv), .stream_in_ready(w_irdy), .stream_in_data(w_id),
      .stream_out_valid(w_ovalid), .stream_out_ready(w_ordy), .stream_out_data(w_odata),
      .level(w_level), .almost_full(w_afull), .out_count(w_oc)
   );

   // ---------------- reference models: contents as queues, read count as integer
   logic [7:0]   sq[$];
   logic [127:0] wq[$];
   logic [31:0]  sm_oc = '0, wm_oc = '0;
   bit           sm_known = 1'b0, wm_known = 1'b0;

   always @(posedge clk) begin
      bit wr, rd;
      if (!s_rst_n) begin
         sq.delete(); sm_oc = '0; sm_known = 1'b1;
      end else if (sm_known) begin
         if (s_flush) sq.delete();
         else begin
            wr = s_iv && (sq.size() < 4);
            rd = (sq.size() > 0) && s_ordy;
            if (rd) begin void'(sq.pop_front()); sm_oc = sm_oc + 32'd1; end
            if (wr) sq.push_back(s_id);
         end
      end
      if (!w_rst_n) begin
         wq.delete(); wm_oc = '0; wm_known = 1'b1;
      end else if (wm_known) begin
         if (w_flush) wq.delete();
         else begin
            wr = w_iv && (wq.size() < 16);
            rd = (wq.size() > 0) && w_ordy;
            if (rd) begin void'(wq.pop_front()); wm_oc = wm_oc + 32'd1; end
            if (wr) wq.push_back(w_id);
         end
      end
   end

   // ---------------- per-cycle compare against the models
   logic [7:0] got[$];

   always @(negedge clk) begin
      if (sm_known) begin
         chk("s_in_ready",  128'(s_irdy),   128'(s_rst_n && (sq.size() != 4)));
         chk("s_out_valid", 128'(s_ovalid), 128'(sq.size() != 0));
         chk("s_out_data",  128'(s_odata),  (sq.size() != 0) ? 128'(sq[0]) : 128'(0));
         chk("s_level",     128'(s_level),  128'(sq.size()));
         chk("s_afull",     128'(s_afull),  128'(sq.size() >= 3));
         chk("s_out_count", 128'(s_oc),     128'(sm_oc));
         if (s_rst_n && !s_flush && s_ovalid && s_ordy) got.push_back(s_odata);
      end
      if (wm_known) begin
         chk("w_in_ready",  128'(w_irdy),   128'(w_rst_n && (wq.size() != 16)));
         chk("w_out_valid", 128'(w_ovalid), 128'(wq.size() != 0));
         chk("w_out_data",  w_odata,        (wq.size() != 0) ? wq[0] : 128'(0));
         chk("w_level",     128'(w_level),  128'(wq.size()));
         chk("w_afull",     128'(w_afull),  128'(wq.size() >= 15));
         chk("w_out_count", 128'(w_oc),     128'(wm_oc));
      end
   end

   // ---------------- stimulus
   initial begin
      logic [7:0] fill [4];
      logic [7:0] order [6];
      int unsigned sent, rcvd, cyc;
      bit fin, fout;
      fill  = '{8'h11, 8'h22, 8'h33, 8'h44};
      order = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

      // reset held with a valid producer
      s_iv = 1'b1; s_id = 8'hAA;
      repeat (3) step();
      chk("rst_in_ready",  128'(s_irdy),   128'(0));
      chk("rst_out_valid", 128'(s_ovalid), 128'(0));
      chk("rst_level",     128'(s_level),  128'(0));
      chk("rst_out_count", 128'(s_oc),     128'(0));
      s_rst_n = 1'b1; s_iv = 1'b0;
      #1;
      chk("rel_in_ready",  128'(s_irdy),   128'(1));

      // fill to full, fifth word held off
      for (int i = 0; i < 4; i++) begin
         s_iv = 1'b1; s_id = fill[i];
         step();
         chk("fill_head", 128'(s_odata), 128'(8'h11));
         chk("fill_afull", 128'(s_afull), 128'(i >= 2));
      end
      s_id = 8'h55;
      step(); step();
      chk("full_level", 128'(s_level), 128'(4));
      chk("full_ready", 128'(s_irdy),  128'(0));
      chk("full_head",  128'(s_odata), 128'(8'h11));

      // drain two, write two across the wrap, drain all
      s_iv = 1'b0; s_ordy = 1'b1;
      step(); step();
      s_ordy = 1'b0; s_iv = 1'b1; s_id = 8'h55;
      step();
      s_id = 8'h66;
      step();
      s_iv = 1'b0; s_ordy = 1'b1;
      repeat (4) step();
      s_ordy = 1'b0;
      chk("drain_count", 128'(got.size()), 128'(6));
      for (int i = 0; i < 6; i++)
         if (i < got.size()) chk("drain_order", 128'(got[i]), 128'(order[i]));
      chk("drain_out_count", 128'(s_oc),    128'(6));
      chk("drain_level",     128'(s_level), 128'(0));

      // simultaneous read+write at level 2
      s_iv = 1'b1; s_id = 8'h80; step();
      s_id = 8'h81; step();
      s_ordy = 1'b1;
      for (int i = 0; i < 10; i++) begin
         s_id = 8'(8'h82 + i);
         step();
         chk("steady_level", 128'(s_level), 128'(2));
      end
      s_iv = 1'b0;
      step(); step();
      s_ordy = 1'b0;

      // one-cycle latency through an empty FIFO
      chk("lat_empty", 128'(s_ovalid), 128'(0));
      s_iv = 1'b1; s_id = 8'hC3;
      step();
      s_iv = 1'b0;
      chk("lat_valid", 128'(s_ovalid), 128'(1));
      chk("lat_data",  128'(s_odata),  128'(8'hC3));
      s_ordy = 1'b1; step(); s_ordy = 1'b0;
      chk("pre_flush_count", 128'(s_oc), 128'(19));

      // flush during a write+read cycle at level 3
      s_iv = 1'b1;
      s_id = 8'hA1; step();
      s_id = 8'hA2; step();
      s_id = 8'hA3; step();
      s_flush = 1'b1; s_id = 8'hEE; s_ordy = 1'b1;
      #1;
      chk("flush_cyc_ready", 128'(s_irdy),   128'(1));
      chk("flush_cyc_valid", 128'(s_ovalid), 128'(1));
      step();
      s_flush = 1'b0; s_iv = 1'b0; s_ordy = 1'b0;
      chk("flush_level", 128'(s_level),  128'(0));
      chk("flush_valid", 128'(s_ovalid), 128'(0));
      chk("flush_data",  128'(s_odata),  128'(0));
      chk("flush_count", 128'(s_oc),     128'(19));
      s_iv = 1'b1; s_id = 8'h5A; step(); s_iv = 1'b0;
      chk("post_flush_level", 128'(s_level), 128'(1));
      chk("post_flush_data",  128'(s_odata), 128'(8'h5A));
      s_ordy = 1'b1; step(); s_ordy = 1'b0;

      // reset mid-operation with handshakes in the reset cycle
      s_iv = 1'b1; s_id = 8'h01; step();
      s_id = 8'h02; step();
      s_rst_n = 1'b0; s_ordy = 1'b1; step();
      s_rst_n = 1'b1; s_iv = 1'b0; s_ordy = 1'b0;
      chk("midrst_level", 128'(s_level),  128'(0));
      chk("midrst_valid", 128'(s_ovalid), 128'(0));
      chk("midrst_count", 128'(s_oc),     128'(0));

      // random throttling with occasional flush/reset on the small instance
      for (int i = 0; i < 400; i++) begin
         s_rst_n = ($urandom_range(0, 49) != 0);
         s_flush = ($urandom_range(0, 19) == 0);
         s_iv    = 1'($urandom_range(0, 1));
         s_ordy  = 1'($urandom_range(0, 1));
         s_id    = 8'($urandom);
         step();
      end
      s_rst_n = 1'b1; s_flush = 1'b0; s_iv = 1'b0; s_ordy = 1'b0;

      // wide instance: 1000 words with random valid/ready throttling
      w_rst_n = 1'b1;
      sent = 0; rcvd = 0; cyc = 0;
      w_id = {$urandom, $urandom, $urandom, $urandom};
      while (rcvd < 1000 && cyc < 20000) begin
         if (!(w_iv && !w_irdy)) begin
            w_iv = (sent < 1000) && ($urandom_range(0, 9) < 7);
            if (w_iv) w_id = {$urandom, $urandom, $urandom, $urandom};
         end
         w_ordy = ($urandom_range(0, 9) < 6);
         #1;
         fin  = w_iv && w_irdy;
         fout = w_ovalid && w_ordy;
         step();
         if (fin)  sent++;
         if (fout) rcvd++;
         cyc++;
      end
      w_iv = 1'b0; w_ordy = 1'b0;
      chk("wide_timeout",   128'(cyc < 20000), 128'(1));
      chk("wide_out_count", 128'(w_oc),        128'(1000));
      chk("wide_level",     128'(w_level),     128'(0));
      step(); step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
